// File: rtl/throttle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : throttle_pkg
// Purpose  : Step table defaults and FSM encodings shared by throttle and meter
// Revision : 1.0 - initial release
// ============================================================================
package throttle_pkg;

  localparam int DEF_CNT_W     = 24;
  localparam int DEF_STEP_W    = 3;
  localparam int DEF_NUM_STEPS = 6;
  localparam int DEF_DIV_BASE  = 4;
  localparam int DEF_DIV_STEP  = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_t;

  typedef enum logic [0:0] {
    DEC_IDLE = 1'b0,
    DEC_RUN  = 1'b1
  } dec_state_t;

  // Full output period, in system clocks, produced by the throttle at step k.
  function automatic int step_period(int base, int step, int k);
    return 2 * (base + k * step);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : 2-flop synchroniser with registered rise/fall pulses (3-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Measures the divided clock period, decodes the throttle step and
//            reports lock/stall. Define FREQ_METER_DUTY_EN to add high_time.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter
  import throttle_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int DIV_BASE  = DEF_DIV_BASE,
  parameter int DIV_STEP  = DEF_DIV_STEP,
  parameter int TOL       = 1,
  parameter int LOCK_CNT  = 3,
  parameter int TIMEOUT   = 2**CNT_W - 1
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              slow_clk_in,
  output logic [CNT_W-1:0]  period,
  output logic              period_vld,
  output logic [STEP_W-1:0] freq_num,
  output logic              freq_vld,
  output logic              freq_err,
  output logic              lock,
  output logic              stall
`ifdef FREQ_METER_DUTY_EN
  ,
  output logic [CNT_W-1:0]  high_time
`endif
);

  localparam int                LC_W      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [STEP_W-1:0] LAST_K    = STEP_W'(NUM_STEPS - 1);
  localparam logic [LC_W-1:0]   LOCK_C    = LC_W'(LOCK_CNT);
  localparam logic [CNT_W:0]    TOL_C     = (CNT_W+1)'(TOL);

  logic edge_rise;
`ifdef FREQ_METER_DUTY_EN
  logic edge_fall;
`else
  logic fall_unused;
`endif

  sync_edge u_sync_edge (
    .clk      (CLK_50),
    .rst      (reset),
    .async_in (slow_clk_in),
    .rise     (edge_rise),
`ifdef FREQ_METER_DUTY_EN
    .fall     (edge_fall)
`else
    .fall     (fall_unused)
`endif
  );

  // Target periods indexed by step; slots past NUM_STEPS are never visited.
  logic [CNT_W:0] tgt [2**STEP_W];
  for (genvar g = 0; g < 2**STEP_W; g++) begin : g_tgt
    if (g < NUM_STEPS) begin : g_valid
      assign tgt[g] = (CNT_W+1)'(step_period(DIV_BASE, DIV_STEP, g));
    end else begin : g_unused
      assign tgt[g] = '1;
    end
  end

  meas_state_t       meas_q, meas_d;
  dec_state_t        dec_q, dec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              period_vld_q, period_vld_d;
  logic [STEP_W-1:0] k_q, k_d;
  logic [STEP_W-1:0] freq_num_q, freq_num_d;
  logic              freq_vld_q, freq_vld_d;
  logic              freq_err_q, freq_err_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic              lock_q, lock_d;
  logic              stall_q, stall_d;

  logic              timeout;
  logic              dec_start;
  logic [CNT_W:0]    per_ext;
  logic [CNT_W:0]    diff;
  logic              match;

  // Distance is taken in CNT_W+1 bits so a period near full scale cannot wrap.
  always_comb begin
    per_ext = {1'b0, period_q};
    diff    = (per_ext >= tgt[k_q]) ? (per_ext - tgt[k_q]) : (tgt[k_q] - per_ext);
    match   = (diff <= TOL_C);
  end

  always_comb begin
    meas_d       = meas_q;
    dec_d        = dec_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    k_d          = k_q;
    freq_num_d   = freq_num_q;
    freq_vld_d   = 1'b0;
    freq_err_d   = 1'b0;
    lock_cnt_d   = lock_cnt_q;
    lock_d       = lock_q;
    stall_d      = stall_q;
    timeout      = 1'b0;
    dec_start    = 1'b0;

    case (meas_q)
      IDLE: begin
        if (edge_rise) begin
          meas_d  = MEASURE;
          cnt_d   = CNT_W'(1);
          stall_d = 1'b0;
        end
      end
      MEASURE: begin
        if (cnt_q == TIMEOUT_C) begin
          meas_d  = IDLE;
          stall_d = 1'b1;
          timeout = 1'b1;
        end else if (edge_rise) begin
          period_d     = cnt_q;
          period_vld_d = 1'b1;
          cnt_d        = CNT_W'(1);
          dec_start    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: meas_d = IDLE;
    endcase

    // A fresh period preempts any decode still in flight.
    if (timeout) begin
      dec_d = DEC_IDLE;
    end else if (dec_start) begin
      dec_d = DEC_RUN;
      k_d   = '0;
    end else if (dec_q == DEC_RUN) begin
      if (match) begin
        dec_d      = DEC_IDLE;
        freq_num_d = k_q;
        freq_vld_d = 1'b1;
        if ((lock_cnt_q != '0) && (k_q == freq_num_q)) begin
          if (lock_cnt_q < LOCK_C) begin
            lock_cnt_d = lock_cnt_q + LC_W'(1);
          end
        end else begin
          lock_cnt_d = LC_W'(1);
        end
        lock_d = (lock_cnt_d == LOCK_C);
      end else if (k_q == LAST_K) begin
        dec_d      = DEC_IDLE;
        freq_err_d = 1'b1;
      end else begin
        k_d = k_q + STEP_W'(1);
      end
    end

    if (timeout || freq_err_d) begin
      lock_cnt_d = '0;
      lock_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      meas_q       <= IDLE;
      dec_q        <= DEC_IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      k_q          <= '0;
      freq_num_q   <= '0;
      freq_vld_q   <= 1'b0;
      freq_err_q   <= 1'b0;
      lock_cnt_q   <= '0;
      lock_q       <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      meas_q       <= meas_d;
      dec_q        <= dec_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      k_q          <= k_d;
      freq_num_q   <= freq_num_d;
      freq_vld_q   <= freq_vld_d;
      freq_err_q   <= freq_err_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_q       <= lock_d;
      stall_q      <= stall_d;
    end
  end

  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign freq_num   = freq_num_q;
  assign freq_vld   = freq_vld_q;
  assign freq_err   = freq_err_q;
  assign lock       = lock_q;
  assign stall      = stall_q;

`ifdef FREQ_METER_DUTY_EN
  logic             hi_run_q, hi_run_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;

  // hi_cnt freezes at the detected fall, so it holds the high time until the next rise.
  always_comb begin
    hi_run_d    = hi_run_q;
    hi_cnt_d    = hi_cnt_q;
    high_time_d = high_time_q;
    if (edge_rise) begin
      hi_run_d = 1'b1;
      hi_cnt_d = CNT_W'(1);
    end else if (edge_fall) begin
      hi_run_d = 1'b0;
    end else if (hi_run_q && (hi_cnt_q != '1)) begin
      hi_cnt_d = hi_cnt_q + CNT_W'(1);
    end
    if (period_vld_d) begin
      high_time_d = hi_cnt_q;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      hi_run_q    <= 1'b0;
      hi_cnt_q    <= '0;
      high_time_q <= '0;
    end else begin
      hi_run_q    <= hi_run_d;
      hi_cnt_q    <= hi_cnt_d;
      high_time_q <= high_time_d;
    end
  end

  assign high_time = high_time_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter
// Purpose  : Self-checking bench for freq_meter (step table, lock, stall, reset)
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;
  import throttle_pkg::*;

  localparam int CNT_W  = DEF_CNT_W;
  localparam int STEP_W = DEF_STEP_W;
  localparam int TMO    = 64;

  logic              CLK_50 = 1'b0;
  logic              reset = 1'b1;
  logic              slow_clk_in = 1'b0;
  logic [CNT_W-1:0]  period;
  logic              period_vld;
  logic [STEP_W-1:0] freq_num;
  logic              freq_vld;
  logic              freq_err;
  logic              lock;
  logic              stall;
`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0]  high_time;
`endif

  freq_meter #(.TIMEOUT(TMO)) dut (
    .CLK_50      (CLK_50),
    .reset       (reset),
    .slow_clk_in (slow_clk_in),
    .period      (period),
    .period_vld  (period_vld),
    .freq_num    (freq_num),
    .freq_vld    (freq_vld),
    .freq_err    (freq_err),
    .lock        (lock),
    .stall       (stall)
`ifdef FREQ_METER_DUTY_EN
    ,
    .high_time   (high_time)
`endif
  );

  always #10 CLK_50 = ~CLK_50;

  int cyc = 0;
  always @(posedge CLK_50) cyc <= cyc + 1;

  typedef struct {
    logic err;
    int   num;
    logic lock;
  } dec_exp_t;

  typedef struct {
    int p;
    int h;
    int n;
    int exp_num;
    int exp_lock;
  } seg_t;

  int       errors = 0;
  int       checks = 0;
  int       exp_period_q[$];
  int       exp_high_q[$];
  dec_exp_t exp_dec_q[$];
  int       prev_p = 0;
  int       prev_h = 0;
  int       m_cnt = 0;
  int       m_num = 0;
  int       rise_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference decode from the step table: target 2*(4+2k), tolerance 1, lowest k wins.
  function automatic int decode_step(input int p);
    for (int k = 0; k < 6; k++) begin
      int t;
      t = 2 * (4 + 2 * k);
      if (p >= t - 1 && p <= t + 1) return k;
    end
    return -1;
  endfunction

  task automatic push_interval(input int p, input int h);
    dec_exp_t e;
    int k;
    k = decode_step(p);
    exp_period_q.push_back(p);
    exp_high_q.push_back(h);
    if (k < 0) begin
      m_cnt  = 0;
      e.err  = 1'b1;
      e.num  = m_num;
      e.lock = 1'b0;
    end else begin
      if (m_cnt > 0 && k == m_num) begin
        if (m_cnt < 3) m_cnt++;
      end else begin
        m_cnt = 1;
      end
      m_num  = k;
      e.err  = 1'b0;
      e.num  = k;
      e.lock = (m_cnt >= 3);
    end
    exp_dec_q.push_back(e);
  endtask

  // Advance one cycle and compare any result pulse against the scoreboard.
  task automatic tick();
    int p;
    int h;
    dec_exp_t e;
    @(negedge CLK_50);
    if (!reset) begin
      if (period_vld) begin
        if (exp_period_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_period_vld: got period %0d expected no report", period);
        end else begin
          p = exp_period_q.pop_front();
          h = exp_high_q.pop_front();
          chk("period", 32'(period), p);
`ifdef FREQ_METER_DUTY_EN
          chk("high_time", 32'(high_time), h);
`endif
        end
      end
      if (freq_vld || freq_err) begin
        if (exp_dec_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_decode: got vld %0b err %0b expected no report", freq_vld, freq_err);
        end else begin
          e = exp_dec_q.pop_front();
          chk("freq_err", 32'(freq_err), 32'(e.err));
          chk("freq_vld", 32'(freq_vld), 32'(!e.err));
          chk("freq_num", 32'(freq_num), e.num);
          chk("lock_at_decode", 32'(lock), 32'(e.lock));
        end
      end
    end
  endtask

  // One period of the divided clock starting with a rising edge.
  task automatic drive_period(input int p, input int h);
    slow_clk_in = 1'b1;
    rise_cyc    = cyc;
    if (prev_p != 0) push_interval(prev_p, prev_h);
    prev_p = p;
    prev_h = h;
    repeat (h) tick();
    slow_clk_in = 1'b0;
    repeat (p - h) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_period_vld"}, 32'(period_vld), 0);
    chk({tag, "_freq_num"}, 32'(freq_num), 0);
    chk({tag, "_freq_vld"}, 32'(freq_vld), 0);
    chk({tag, "_freq_err"}, 32'(freq_err), 0);
    chk({tag, "_lock"}, 32'(lock), 0);
    chk({tag, "_stall"}, 32'(stall), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  seg_t segs[10];

  initial begin
    segs[0] = '{p: 8,  h: 4,  n: 4, exp_num: 0, exp_lock: 1};
    segs[1] = '{p: 16, h: 8,  n: 3, exp_num: 2, exp_lock: 0};
    segs[2] = '{p: 17, h: 8,  n: 2, exp_num: 2, exp_lock: 1};
    segs[3] = '{p: 14, h: 7,  n: 2, exp_num: 2, exp_lock: 0};
    segs[4] = '{p: 8,  h: 4,  n: 4, exp_num: 0, exp_lock: 1};
    segs[5] = '{p: 12, h: 4,  n: 4, exp_num: 1, exp_lock: 1};
    segs[6] = '{p: 16, h: 8,  n: 4, exp_num: 2, exp_lock: 1};
    segs[7] = '{p: 20, h: 10, n: 4, exp_num: 3, exp_lock: 1};
    segs[8] = '{p: 24, h: 12, n: 4, exp_num: 4, exp_lock: 1};
    segs[9] = '{p: 28, h: 14, n: 4, exp_num: 5, exp_lock: 1};

    reset = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    foreach (segs[i]) begin
      for (int j = 0; j < segs[i].n; j++) drive_period(segs[i].p, segs[i].h);
      chk($sformatf("seg%0d_freq_num", i), 32'(freq_num), segs[i].exp_num);
      chk($sformatf("seg%0d_lock", i), 32'(lock), segs[i].exp_lock);
    end

    // Reset in the middle of a measurement: interrupted period never reported.
    slow_clk_in = 1'b1;
    if (prev_p != 0) push_interval(prev_p, prev_h);
    prev_p = 0;
    repeat (12) tick();
    slow_clk_in = 1'b0;
    repeat (2) tick();
    chk("queue_empty_before_reset", 32'(exp_period_q.size() + exp_dec_q.size()), 0);
    reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    m_cnt = 0;
    m_num = 0;
    repeat (4) drive_period(8, 4);
    chk("post_reset_freq_num", 32'(freq_num), 0);
    chk("post_reset_lock", 32'(lock), 1);

    // Stall: hold low until cnt hits TIMEOUT, exactly 68 cycles after the last rise.
    drive_period(8, 4);
    prev_p = 0;
    while (cyc < rise_cyc + 67) tick();
    chk("stall_before_timeout", 32'(stall), 0);
    tick();
    chk("stall_at_timeout", 32'(stall), 1);
    chk("lock_at_timeout", 32'(lock), 0);
    m_cnt = 0;
    repeat (10) tick();
    drive_period(16, 8);
    chk("stall_cleared_on_rearm", 32'(stall), 0);
    drive_period(16, 8);
    drive_period(8, 4);
    repeat (20) tick();
    chk("post_stall_freq_num", 32'(freq_num), 2);
    chk("post_stall_lock", 32'(lock), 0);
    chk("queue_empty_at_end", 32'(exp_period_q.size() + exp_dec_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
